bcd_conversion_scheduler: RTL

Shares one iterative double-dabble binary-to-BCD engine among `NUM_REQ` requesters, such as per-display counters feeding the seven-segment drivers. Arbitration is round-robin. Each requester holds a request with its binary operand until it receives a one-cycle acknowledge. Each requester has a dedicated BCD result slot that holds its last converted value until that requester converts again or reset occurs.

---
 rtl/bcd_conversion_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bcd_conversion_scheduler.sv
// Round-robin scheduler sharing one iterative double-dabble binary-to-BCD engine among NUM_REQ requesters.
// Optional feature: define BCD_SCHED_SKIP_UNCHANGED_EN to skip conversion when a requester's operand is unchanged.
module bcd_conversion_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int INPUT_WIDTH    = 7,
  parameter int DECIMAL_DIGITS = 2
) (
  input  logic                                i_Clock,
  input  logic                                i_Reset,
  input  logic [NUM_REQ-1:0]                  i_Req,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0]      i_Binary,
  output logic [NUM_REQ-1:0]                  o_Ack,
  output logic [NUM_REQ*DECIMAL_DIGITS*4-1:0] o_BCD,
  output logic                                o_Busy
);

  localparam int DIGW = DECIMAL_DIGITS * 4;
  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(INPUT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ADJUST,
    SHIFT,
    DONE
  } state_t;

  state_t r_State;
  state_t w_NextState;

  logic [IDXW-1:0]          r_Ptr;
  logic [IDXW-1:0]          r_Winner;
  logic [INPUT_WIDTH-1:0]   r_Shift;
  logic [DIGW-1:0]          r_Scratch;
  logic [CNTW-1:0]          r_Count;
  logic [NUM_REQ-1:0]       r_Ack;
  logic [NUM_REQ*DIGW-1:0]  r_BCD;

  logic [NUM_REQ-1:0]       w_Eligible;
  logic                     w_GrantValid;
  logic [IDXW-1:0]          w_GrantIdx;
  logic [INPUT_WIDTH-1:0]   w_GrantOperand;
  logic [DIGW-1:0]          w_Adjusted;
  logic [IDXW-1:0]          w_NextPtr;
  logic                     w_Skip;

  // A requester being acknowledged this cycle is masked so it cannot be re-granted immediately.
  always_comb begin
    w_Eligible   = i_Req & ~r_Ack;
    w_GrantValid = 1'b0;
    w_GrantIdx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_Eligible[(int'(r_Ptr) + i) % NUM_REQ]) begin
        w_GrantValid = 1'b1;
        w_GrantIdx   = IDXW'((int'(r_Ptr) + i) % NUM_REQ);
      end
    end
  end

  assign w_GrantOperand = i_Binary[w_GrantIdx*INPUT_WIDTH +: INPUT_WIDTH];

  always_comb begin
    w_Adjusted = r_Scratch;
    for (int d = 0; d < DECIMAL_DIGITS; d++) begin
      if (r_Scratch[d*4 +: 4] > 4'd4) begin
        w_Adjusted[d*4 +: 4] = r_Scratch[d*4 +: 4] + 4'd3;
      end
    end
  end

  assign w_NextPtr = (r_Winner == IDXW'(NUM_REQ - 1)) ? '0 : r_Winner + 1'b1;

`ifdef BCD_SCHED_SKIP_UNCHANGED_EN
  logic [INPUT_WIDTH-1:0] r_CacheOp [NUM_REQ];
  logic [NUM_REQ-1:0]     r_CacheValid;
  logic [INPUT_WIDTH-1:0] r_LastOp;

  assign w_Skip = r_CacheValid[w_GrantIdx] && (r_CacheOp[w_GrantIdx] == w_GrantOperand);

  // The operand is kept aside at grant because the shift register is consumed by the conversion.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_CacheValid <= '0;
      r_LastOp     <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        r_CacheOp[k] <= '0;
      end
    end else begin
      if (r_State == IDLE && w_GrantValid) begin
        r_LastOp <= w_GrantOperand;
      end
      if (r_State == DONE) begin
        r_CacheOp[r_Winner]    <= r_LastOp;
        r_CacheValid[r_Winner] <= 1'b1;
      end
    end
  end
`else
  assign w_Skip = 1'b0;
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State <= IDLE;
    end else begin
      r_State <= w_NextState;
    end
  end

  always_comb begin
    w_NextState = r_State;
    case (r_State)
      IDLE: begin
        if (w_GrantValid) begin
          w_NextState = w_Skip ? DONE : ADJUST;
        end
      end
      ADJUST: w_NextState = SHIFT;
      SHIFT: begin
        if (r_Count == CNTW'(1)) begin
          w_NextState = DONE;
        end else begin
          w_NextState = ADJUST;
        end
      end
      DONE:    w_NextState = IDLE;
      default: w_NextState = IDLE;
    endcase
  end

  // A skipped conversion preloads the scratch with the existing slot so DONE simply rewrites it.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Ptr     <= '0;
      r_Winner  <= '0;
      r_Shift   <= '0;
      r_Scratch <= '0;
      r_Count   <= '0;
      r_Ack     <= '0;
      r_BCD     <= '0;
    end else begin
      r_Ack <= '0;
      case (r_State)
        IDLE: begin
          if (w_GrantValid) begin
            r_Winner  <= w_GrantIdx;
            r_Shift   <= w_GrantOperand;
            r_Scratch <= w_Skip ? r_BCD[w_GrantIdx*DIGW +: DIGW] : '0;
            r_Count   <= CNTW'(INPUT_WIDTH);
          end
        end
        ADJUST: begin
          r_Scratch <= w_Adjusted;
        end
        SHIFT: begin
          {r_Scratch, r_Shift} <= {r_Scratch[DIGW-2:0], r_Shift, 1'b0};
          r_Count              <= r_Count - 1'b1;
        end
        DONE: begin
          r_BCD[r_Winner*DIGW +: DIGW] <= r_Scratch;
          r_Ack[r_Winner]              <= 1'b1;
          r_Ptr                        <= w_NextPtr;
        end
        default: ;
      endcase
    end
  end

  assign o_Ack  = r_Ack;
  assign o_BCD  = r_BCD;
  assign o_Busy = (r_State != IDLE);

endmodule
